program_feeder: RTL and testbench
=================================

Name: program_feeder

Overview:
- Stimulus-side counterpart of the Processor top: it drives the processor's input side and receives its output side.
- Holds a small program buffer that is loaded one instruction per cycle, then streams it to the processor in order.
- Honours the processor's stall indication, drains the 3-stage pipeline (ID/EX/WB) with NOPs, and collects write-back results.
- Used both as the on-chip program source and as the reference driver for the UVM bench.

Parameters:
INSTR_W, 16, instruction word width
DATA_W, 8, processor result width
DEPTH, 16, program buffer entries (power of 2)
PIPE_DEPTH, 3, NOP cycles issued after the last instruction to drain the pipeline
NOP_WORD, 16'h0000, instruction driven when no program word is being issued

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-high
load_valid  in  1  write load_instr into the buffer this cycle
load_instr  in  INSTR_W  instruction to append
start  in  1  one-cycle pulse; begin execution of the loaded program
proc_reset  out  1  reset to the processor
instr_out  out  INSTR_W  instruction presented to the processor
instr_valid  out  1  instr_out holds a real program word
proc_stalled  in  1  processor stalled; the word presented this cycle is not accepted
proc_result  in  DATA_W  processor write-back data
proc_result_valid  in  1  proc_result is valid this cycle
prog_len  out  $clog2(DEPTH)+1  number of loaded instructions
result_count  out  $clog2(DEPTH)+1  results captured since start
last_result  out  DATA_W  most recent captured result
load_overflow  out  1  sticky flag: a load was attempted while the buffer was full
busy  out  1  high in START_RST, RUN and DRAIN
done  out  1  high in DONE

Behaviour:
- Reset values (reset=1 on an edge):
  - state=IDLE; prog_len=0; rd_ptr=0; result_count=0; last_result=0.
  - load_overflow=0; proc_reset=1; instr_out=NOP_WORD; instr_valid=0; busy=0; done=0.
- States: IDLE, START_RST, RUN, DRAIN, DONE.
- IDLE:
  - proc_reset=0; outputs hold NOP_WORD with instr_valid=0.
  - load_valid with prog_len<DEPTH writes buf[prog_len] and increments prog_len the next cycle.
  - load_valid with prog_len==DEPTH drops the word and sets load_overflow.
  - start=1 moves to START_RST. If load_valid and start are both high, the load is performed and included in the run.
- START_RST:
  - Lasts exactly 1 cycle; proc_reset=1.
  - Clears rd_ptr, result_count and last_result.
  - Next state is RUN if prog_len>0, else DRAIN.
- RUN:
  - instr_out=buf[rd_ptr]; instr_valid=1. The output is combinational from rd_ptr, so there is zero latency from pointer to pin.
  - Accept occurs when instr_valid && !proc_stalled. On accept rd_ptr increments.
  - When proc_stalled=1, rd_ptr holds and the same word is re-presented the next cycle. There is no limit on consecutive stall cycles.
  - Accept with rd_ptr==prog_len-1 moves to DRAIN.
- DRAIN:
  - instr_out=NOP_WORD; instr_valid=0.
  - A drain counter counts PIPE_DEPTH cycles in which proc_stalled=0; stalled cycles do not count.
  - Then moves to DONE.
- DONE:
  - done=1 and all results are held.
  - start=1 re-runs the same program (goes to START_RST); the buffer is preserved.
  - load_valid=1 resets prog_len to 1, writes buf[0] and clears load_overflow. This starts a new program; the next state is IDLE.
- Result capture:
  - Active in RUN and DRAIN, and in the first cycle of DONE (the last result may arrive on the DRAIN→DONE edge).
  - proc_result_valid=1 sets last_result=proc_result and increments result_count. result_count saturates at 2^($clog2(DEPTH)+1)-1.
- Ignored inputs: start while busy is ignored; load_valid in START_RST, RUN or DRAIN is ignored and does not set overflow.
- Reset mid-operation: any state returns to IDLE next cycle and the buffer length is cleared (contents need not be cleared). proc_reset is asserted while reset is high.
- proc_reset is registered (no glitches).

Test Plan:
1. Load 4 words 0x1111,0x2222,0x3333,0x4444, pulse start, proc_stalled=0 → START_RST for 1 cycle; then 4 consecutive cycles with instr_valid=1 showing the words in order; then 3 NOP cycles; done=1 on cycle 9 after start.
2. Same program with proc_stalled=1 for 2 cycles while 0x2222 is presented → 0x2222 is held for 3 cycles total, no word is skipped or duplicated after release; done is delayed by exactly 2 cycles.
3. Load 17 words into a DEPTH=16 buffer → prog_len=16; load_overflow=1; the run issues only the first 16 words.
4. Pulse start with prog_len=0 → START_RST, then DRAIN (3 cycles), then DONE; instr_valid is never 1; result_count=0.
5. During RUN, drive proc_result_valid=1 with data 0x05 then 0xA7 → result_count=2; last_result=0xA7; pulse start in DONE → result_count and last_result are cleared in START_RST and the program reissues identically.
6. Assert reset while rd_ptr=2 in RUN → next cycle state=IDLE, prog_len=0, instr_valid=0, proc_reset=1 while reset is high; a subsequent start with an empty buffer behaves as in scenario 4.

Source files
------------

// File: rtl/program_feeder.sv
// program_feeder: loads a small program one word per cycle, then streams it to the
// processor in order. It honours the processor's stall, drains the pipeline with NOPs,
// and captures the write-back results.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   load_valid/instr      append one instruction to the program buffer
//   start                 one-cycle pulse that begins execution of the loaded program
//   proc_reset            registered reset to the processor
//   instr_out/valid       instruction presented to the processor
//   proc_stalled          processor did not accept the word presented this cycle
//   proc_result[_valid]   processor write-back data
//   prog_len              number of loaded instructions
//   result_count          results captured since start (saturating)
//   last_result           most recent captured result
//   load_overflow         sticky flag: a load was attempted while the buffer was full
//   busy / done           status
module program_feeder #(
  parameter int unsigned        INSTR_W    = 16,
  parameter int unsigned        DATA_W     = 8,
  parameter int unsigned        DEPTH      = 16,
  parameter int unsigned        PIPE_DEPTH = 3,
  parameter logic [INSTR_W-1:0] NOP_WORD   = {INSTR_W{1'b0}}
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       load_valid,
  input  logic [INSTR_W-1:0]         load_instr,
  input  logic                       start,
  output logic                       proc_reset,
  output logic [INSTR_W-1:0]         instr_out,
  output logic                       instr_valid,
  input  logic                       proc_stalled,
  input  logic [DATA_W-1:0]          proc_result,
  input  logic                       proc_result_valid,
  output logic [$clog2(DEPTH):0]     prog_len,
  output logic [$clog2(DEPTH):0]     result_count,
  output logic [DATA_W-1:0]          last_result,
  output logic                       load_overflow,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned DrainW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

  typedef enum logic [2:0] {StIdle, StStartRst, StRun, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     prog_len_q, prog_len_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DrainW-1:0]   drain_q, drain_d;
  logic                ovf_q, ovf_d;
  logic [CntW-1:0]     result_count_q;
  logic [DATA_W-1:0]   last_result_q;
  logic                first_done_q;
  logic                proc_reset_q;
  logic                mem_we;
  logic [PtrW-1:0]     mem_waddr;
  logic                capture_en;

  logic [INSTR_W-1:0]  prog_mem [DEPTH];

  always_comb begin
    state_d    = state_q;
    prog_len_d = prog_len_q;
    rd_ptr_d   = rd_ptr_q;
    drain_d    = drain_q;
    ovf_d      = ovf_q;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    unique case (state_q)
      StIdle: begin
        if (load_valid) begin
          if (prog_len_q < CntW'(DEPTH)) begin
            mem_we     = 1'b1;
            mem_waddr  = prog_len_q[PtrW-1:0];
            prog_len_d = prog_len_q + CntW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (start) state_d = StStartRst;
      end
      StStartRst: begin
        rd_ptr_d = '0;
        drain_d  = '0;
        state_d  = (prog_len_q != '0) ? StRun : StDrain;
      end
      StRun: begin
        if (!proc_stalled) begin
          rd_ptr_d = rd_ptr_q + PtrW'(1);
          if ({1'b0, rd_ptr_q} == prog_len_q - CntW'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        // Only cycles the processor actually advances count towards the drain.
        if (!proc_stalled) begin
          if (drain_q == DrainW'(PIPE_DEPTH - 1)) state_d = StDone;
          else                                    drain_d = drain_q + DrainW'(1);
        end
      end
      StDone: begin
        // A new load takes precedence over a re-run: it begins a new program.
        if (load_valid) begin
          mem_we     = 1'b1;
          mem_waddr  = '0;
          prog_len_d = CntW'(1);
          ovf_d      = 1'b0;
          state_d    = StIdle;
        end else if (start) begin
          state_d = StStartRst;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The final result may land on the DRAIN->DONE edge, so capture stays open one extra cycle.
  assign capture_en = (state_q == StRun) || (state_q == StDrain) ||
                      ((state_q == StDone) && first_done_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      prog_len_q     <= '0;
      rd_ptr_q       <= '0;
      drain_q        <= '0;
      ovf_q          <= 1'b0;
      result_count_q <= '0;
      last_result_q  <= '0;
      first_done_q   <= 1'b0;
      proc_reset_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      prog_len_q   <= prog_len_d;
      rd_ptr_q     <= rd_ptr_d;
      drain_q      <= drain_d;
      ovf_q        <= ovf_d;
      first_done_q <= (state_d == StDone) && (state_q != StDone);
      proc_reset_q <= (state_d == StStartRst);
      if (state_q == StStartRst) begin
        result_count_q <= '0;
        last_result_q  <= '0;
      end else if (capture_en && proc_result_valid) begin
        last_result_q <= proc_result;
        if (result_count_q != '1) result_count_q <= result_count_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && mem_we) prog_mem[mem_waddr] <= load_instr;
  end

  assign proc_reset    = proc_reset_q;
  assign instr_valid   = (state_q == StRun);
  assign instr_out     = (state_q == StRun) ? prog_mem[rd_ptr_q] : NOP_WORD;
  assign prog_len      = prog_len_q;
  assign result_count  = result_count_q;
  assign last_result   = last_result_q;
  assign load_overflow = ovf_q;
  assign busy          = (state_q == StStartRst) || (state_q == StRun) || (state_q == StDrain);
  assign done          = (state_q == StDone);

endmodule

// File: tb/tb_program_feeder.sv
module tb_program_feeder;

  localparam int PIPE = 3;
  localparam int M_IDLE = 0, M_SRST = 1, M_RUN = 2, M_DRAIN = 3, M_DONE = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic [15:0] load_instr = '0;
  logic        start = 1'b0;
  logic        proc_reset;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        proc_stalled = 1'b0;
  logic [7:0]  proc_result = '0;
  logic        proc_result_valid = 1'b0;
  logic [4:0]  prog_len;
  logic [4:0]  result_count;
  logic [7:0]  last_result;
  logic        load_overflow;
  logic        busy;
  logic        done;

  program_feeder dut (
    .clock             (clock),
    .reset             (reset),
    .load_valid        (load_valid),
    .load_instr        (load_instr),
    .start             (start),
    .proc_reset        (proc_reset),
    .instr_out         (instr_out),
    .instr_valid       (instr_valid),
    .proc_stalled      (proc_stalled),
    .proc_result       (proc_result),
    .proc_result_valid (proc_result_valid),
    .prog_len          (prog_len),
    .result_count      (result_count),
    .last_result       (last_result),
    .load_overflow     (load_overflow),
    .busy              (busy),
    .done              (done)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what has been loaded, how many words issued, NOPs still owed.
  logic [15:0] m_mem [16];
  int          m_state = M_IDLE;
  int          m_len = 0;
  int          m_issued = 0;
  int          m_nops_left = 0;
  int          m_cnt = 0;
  int          m_last = 0;
  bit          m_ovf = 0;
  bit          m_first = 0;
  bit          m_preset = 1;
  bit          m_valid = 0;

  always @(posedge clock) begin
    int  ns;
    bit  cap;
    if (reset) begin
      m_state = M_IDLE; m_len = 0; m_issued = 0; m_nops_left = 0;
      m_cnt = 0; m_last = 0; m_ovf = 0; m_first = 0; m_preset = 1; m_valid = 1;
    end else begin
      ns  = m_state;
      cap = proc_result_valid &&
            (m_state == M_RUN || m_state == M_DRAIN || (m_state == M_DONE && m_first));
      case (m_state)
        M_IDLE: begin
          if (load_valid) begin
            if (m_len < 16) begin m_mem[m_len] = load_instr; m_len++; end
            else m_ovf = 1;
          end
          if (start) ns = M_SRST;
        end
        M_SRST: begin
          m_issued = 0;
          m_nops_left = PIPE;
          ns = (m_len > 0) ? M_RUN : M_DRAIN;
        end
        M_RUN: if (!proc_stalled) begin
          m_issued++;
          if (m_issued == m_len) ns = M_DRAIN;
        end
        M_DRAIN: if (!proc_stalled) begin
          m_nops_left--;
          if (m_nops_left == 0) ns = M_DONE;
        end
        M_DONE: begin
          if (load_valid) begin
            m_mem[0] = load_instr; m_len = 1; m_ovf = 0; ns = M_IDLE;
          end else if (start) ns = M_SRST;
        end
        default: ns = M_IDLE;
      endcase
      if (m_state == M_SRST) begin
        m_cnt = 0; m_last = 0;
      end else if (cap) begin
        m_last = int'(proc_result);
        if (m_cnt < 31) m_cnt++;
      end
      m_first  = (ns == M_DONE) && (m_state != M_DONE);
      m_preset = (ns == M_SRST);
      m_state  = ns;
    end
  end

  always @(negedge clock) begin
    logic [15:0] m_instr;
    if (m_valid) begin
      m_instr = (m_state == M_RUN) ? m_mem[m_issued] : 16'h0000;
      check("cmp_proc_reset",   32'(proc_reset),    32'(m_preset));
      check("cmp_instr_valid",  32'(instr_valid),   32'(m_state == M_RUN));
      check("cmp_instr_out",    32'(instr_out),     32'(m_instr));
      check("cmp_prog_len",     32'(prog_len),      32'(m_len));
      check("cmp_result_count", 32'(result_count),  32'(m_cnt));
      check("cmp_last_result",  32'(last_result),   32'(m_last));
      check("cmp_overflow",     32'(load_overflow), 32'(m_ovf));
      check("cmp_busy",         32'(busy),
            32'(m_state == M_SRST || m_state == M_RUN || m_state == M_DRAIN));
      check("cmp_done",         32'(done),          32'(m_state == M_DONE));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
  endtask

  task automatic load_word(input logic [15:0] w);
    load_valid = 1'b1; load_instr = w; step(); load_valid = 1'b0;
  endtask

  logic [15:0] acc_q[$];
  logic [15:0] exp_words [17];
  int          valid_cycles;
  int          hits;
  int          rc2;
  int          lr2;

  // Pulses start and runs until done; cycle 1 is the START_RST cycle.
  task automatic run_prog(input logic [15:0] stall_on, input int n_stall,
                          input int ra_cyc, input logic [7:0] ra,
                          input int rb_cyc, input logic [7:0] rb, output int done_cyc);
    int cyc;
    int stalled;
    acc_q.delete();
    valid_cycles = 0; hits = 0; stalled = 0; rc2 = -1; lr2 = -1;
    start = 1'b1; step(); start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      proc_stalled = 1'b0;
      if (instr_valid && instr_out == stall_on) begin
        hits++;
        if (stalled < n_stall) begin proc_stalled = 1'b1; stalled++; end
      end
      if (instr_valid) valid_cycles++;
      if (instr_valid && !proc_stalled) acc_q.push_back(instr_out);
      proc_result_valid = (cyc == ra_cyc) || (cyc == rb_cyc);
      proc_result       = (cyc == ra_cyc) ? ra : rb;
      if (cyc == 2) begin rc2 = int'(result_count); lr2 = int'(last_result); end
      step();
      cyc++;
    end
    proc_stalled = 1'b0; proc_result_valid = 1'b0;
    done_cyc = (done === 1'b1) ? cyc : -1;
  endtask

  task automatic check_words(input string name, input int n);
    check({name, "_count"}, 32'(acc_q.size()), 32'(n));
    for (int i = 0; i < n && i < acc_q.size(); i++) check(name, 32'(acc_q[i]), 32'(exp_words[i]));
  endtask

  initial begin
    int dc;
    exp_words[0] = 16'h1111; exp_words[1] = 16'h2222;
    exp_words[2] = 16'h3333; exp_words[3] = 16'h4444;

    do_reset();
    check("reset_prog_len", 32'(prog_len), 32'd0);
    check("reset_instr_valid", 32'(instr_valid), 32'd0);
    check("reset_done", 32'(done), 32'd0);

    // Basic four-word program
    for (int i = 0; i < 4; i++) load_word(exp_words[i]);
    check("s1_prog_len", 32'(prog_len), 32'd4);
    run_prog(16'hFFFF, 0, 0, 8'h0, 0, 8'h0, dc);
    check("s1_done_cycle", 32'(dc), 32'd9);
    check_words("s1_word", 4);

    // Two stall cycles on the second word
    run_prog(16'h2222, 2, 0, 8'h0, 0, 8'h0, dc);
    check("s2_done_cycle", 32'(dc), 32'd11);
    check("s2_hold_cycles", 32'(hits), 32'd3);
    check_words("s2_word", 4);

    // Overflow: 17 loads into 16 entries
    do_reset();
    for (int i = 0; i < 17; i++) begin
      exp_words[i] = 16'hA000 + 16'(i);
      load_word(exp_words[i]);
    end
    check("s3_prog_len", 32'(prog_len), 32'd16);
    check("s3_overflow", 32'(load_overflow), 32'd1);
    run_prog(16'hFFFF, 0, 0, 8'h0, 0, 8'h0, dc);
    check("s3_done_cycle", 32'(dc), 32'd21);
    check_words("s3_word", 16);
    load_word(16'h5A5A);
    check("s3_reload_len", 32'(prog_len), 32'd1);
    check("s3_reload_ovf", 32'(load_overflow), 32'd0);
    check("s3_reload_done", 32'(done), 32'd0);

    // Empty program
    do_reset();
    run_prog(16'hFFFF, 0, 0, 8'h0, 0, 8'h0, dc);
    check("s4_done_cycle", 32'(dc), 32'd5);
    check("s4_valid_cycles", 32'(valid_cycles), 32'd0);
    check("s4_result_count", 32'(result_count), 32'd0);

    // Result capture and clearing on re-run
    do_reset();
    exp_words[0] = 16'h1111; exp_words[1] = 16'h2222;
    exp_words[2] = 16'h3333; exp_words[3] = 16'h4444;
    for (int i = 0; i < 4; i++) load_word(exp_words[i]);
    run_prog(16'hFFFF, 0, 3, 8'h05, 4, 8'hA7, dc);
    check("s5_result_count", 32'(result_count), 32'd2);
    check("s5_last_result", 32'(last_result), 32'hA7);
    run_prog(16'hFFFF, 0, 0, 8'h0, 0, 8'h0, dc);
    check("s5_rc_cleared", 32'(rc2), 32'd0);
    check("s5_lr_cleared", 32'(lr2), 32'd0);
    check("s5_done_cycle", 32'(dc), 32'd9);
    check_words("s5_word", 4);

    // Reset in the middle of a run
    do_reset();
    for (int i = 0; i < 4; i++) load_word(exp_words[i]);
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    check("s6_word_at_ptr2", 32'(instr_out), 32'h3333);
    reset = 1'b1; step();
    check("s6_instr_valid", 32'(instr_valid), 32'd0);
    check("s6_prog_len", 32'(prog_len), 32'd0);
    check("s6_proc_reset", 32'(proc_reset), 32'd1);
    check("s6_busy", 32'(busy), 32'd0);
    step();
    check("s6_proc_reset_hold", 32'(proc_reset), 32'd1);
    reset = 1'b0; step();
    check("s6_proc_reset_rel", 32'(proc_reset), 32'd0);
    run_prog(16'hFFFF, 0, 0, 8'h0, 0, 8'h0, dc);
    check("s6_done_cycle", 32'(dc), 32'd5);
    check("s6_valid_cycles", 32'(valid_cycles), 32'd0);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 1500; i++) begin
      reset             = ($urandom_range(0, 299) == 0);
      load_valid        = ($urandom_range(0, 3) == 0);
      load_instr        = 16'($urandom);
      start             = !load_valid && ($urandom_range(0, 14) == 0);
      proc_stalled      = ($urandom_range(0, 2) == 0);
      proc_result_valid = ($urandom_range(0, 2) == 0);
      proc_result       = 8'($urandom);
      step();
    end
    reset = 1'b0; load_valid = 1'b0; start = 1'b0;
    proc_stalled = 1'b0; proc_result_valid = 1'b0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
